// File: rtl/alu_result_select.sv
// Selects one of NUM_IN packed inputs and queues the value with its select
// code in a two-entry FIFO; out-of-range selects yield zero data and a sticky error.
module alu_result_select #(
  parameter int WIDTH  = 32,
  parameter int NUM_IN = 8,
  parameter int SEL_W  = 3
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_IN*WIDTH-1:0] in_bus,
  input  logic [SEL_W-1:0]        sel,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic [SEL_W-1:0]        out_sel,
  output logic                    out_zero,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    sel_err,
  input  logic                    clr_err
);

  localparam logic [1:0] EMPTY = 2'd0;
  localparam logic [1:0] ONE   = 2'd1;
  localparam logic [1:0] TWO   = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] head_data;
  logic [WIDTH-1:0] tail_data;
  logic [SEL_W-1:0] head_sel;
  logic [SEL_W-1:0] tail_sel;
  logic [WIDTH-1:0] cap_data;
  logic             sel_bad;
  logic             accept;
  logic             pop;

  // Handshake: a transfer happens on a rising edge where valid and ready are
  // both high; valid must not wait on ready, and ready is a pure function of
  // registered state so no combinational path runs from out_ready to in_ready.
  assign accept    = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign in_ready  = (state != TWO);
  assign out_valid = (state != EMPTY);
  assign out_data  = head_data;
  assign out_sel   = head_sel;
  assign out_zero  = out_valid && (head_data == '0);

  // Selects that match no input leave the captured data at zero.
  always_comb begin
    cap_data = '0;
    sel_bad  = 1'b1;
    for (int k = 0; k < NUM_IN; k++) begin
      if (sel == SEL_W'(k)) begin
        cap_data = in_bus[k*WIDTH +: WIDTH];
        sel_bad  = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= EMPTY;
      head_data <= '0;
      head_sel  <= '0;
      tail_data <= '0;
      tail_sel  <= '0;
    end else begin
      case (state)
        EMPTY: begin
          if (accept) begin
            head_data <= cap_data;
            head_sel  <= sel;
            state     <= ONE;
          end
        end
        ONE: begin
          if (accept && !pop) begin
            tail_data <= cap_data;
            tail_sel  <= sel;
            state     <= TWO;
          end else if (accept && pop) begin
            head_data <= cap_data;
            head_sel  <= sel;
          end else if (pop) begin
            state <= EMPTY;
          end
        end
        TWO: begin
          if (pop) begin
            head_data <= tail_data;
            head_sel  <= tail_sel;
            state     <= ONE;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

  // A new error wins over a simultaneous clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      sel_err <= 1'b0;
    end else if (accept && sel_bad) begin
      sel_err <= 1'b1;
    end else if (clr_err) begin
      sel_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_result_select.sv
// Bench for alu_result_select: queue-based model checked every cycle on the
// default configuration, plus directed vectors on a NUM_IN=6 instance.
module tb_alu_result_select;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic [8*W-1:0] in_bus;
  logic [2:0]    sel;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  out_data;
  logic [2:0]    out_sel;
  logic          out_zero;
  logic          out_valid;
  logic          out_ready;
  logic          sel_err;
  logic          clr_err;

  logic [6*W-1:0] in_bus6;
  logic [2:0]    sel6;
  logic          in_valid6;
  logic          in_ready6;
  logic [W-1:0]  out_data6;
  logic [2:0]    out_sel6;
  logic          out_zero6;
  logic          out_valid6;
  logic          out_ready6;
  logic          sel_err6;
  logic          clr_err6;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  alu_result_select #(.WIDTH(W), .NUM_IN(8), .SEL_W(3)) dut (
    .clk(clk), .reset(reset), .in_bus(in_bus), .sel(sel), .in_valid(in_valid),
    .in_ready(in_ready), .out_data(out_data), .out_sel(out_sel), .out_zero(out_zero),
    .out_valid(out_valid), .out_ready(out_ready), .sel_err(sel_err), .clr_err(clr_err)
  );

  alu_result_select #(.WIDTH(W), .NUM_IN(6), .SEL_W(3)) dut6 (
    .clk(clk), .reset(reset), .in_bus(in_bus6), .sel(sel6), .in_valid(in_valid6),
    .in_ready(in_ready6), .out_data(out_data6), .out_sel(out_sel6), .out_zero(out_zero6),
    .out_valid(out_valid6), .out_ready(out_ready6), .sel_err(sel_err6), .clr_err(clr_err6)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Model: queue of {sel, data}, depth two, updated from the inputs seen at each edge.
  logic [W+2:0] exp_q[$];
  bit           m_err   = 1'b0;
  bit           started = 1'b0;

  always @(posedge clk) begin
    bit acc;
    bit pp;
    int k;
    if (reset) begin
      exp_q.delete();
      m_err   = 1'b0;
      started = 1'b1;
    end else begin
      acc = in_valid && (exp_q.size() < 2);
      pp  = (exp_q.size() > 0) && out_ready;
      k   = int'(sel);
      if (acc && k >= 8) m_err = 1'b1;
      else if (clr_err)  m_err = 1'b0;
      if (pp) void'(exp_q.pop_front());
      if (acc) exp_q.push_back({sel, (k < 8) ? in_bus[k*W +: W] : 32'h0});
    end
  end

  always @(negedge clk) begin
    logic [W+2:0] h;
    if (started) begin
      chk("in_ready", in_ready, exp_q.size() < 2);
      chk("out_valid", out_valid, exp_q.size() != 0);
      chk("sel_err", sel_err, m_err);
      if (exp_q.size() != 0) begin
        h = exp_q[0];
        chk("out_data", out_data, h[W-1:0]);
        chk("out_sel", out_sel, h[W+2:W]);
        chk("out_zero", out_zero, h[W-1:0] == '0);
      end else begin
        chk("out_zero_idle", out_zero, 1'b0);
      end
    end
  end

  initial begin
    reset = 1'b1; in_valid = 1'b0; sel = '0; out_ready = 1'b0; clr_err = 1'b0;
    in_valid6 = 1'b0; sel6 = '0; out_ready6 = 1'b0; clr_err6 = 1'b0;
    for (int k = 0; k < 8; k++) in_bus[k*W +: W] = 32'h1000_0000 + k;
    for (int k = 0; k < 6; k++) in_bus6[k*W +: W] = 32'h2000_0000 + k;
    step(); step();
    reset = 1'b0;
    @(negedge clk);
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_ready", in_ready, 1'b1);
    chk("rst_data", out_data, 32'h0);
    chk("rst_sel", out_sel, 3'd0);
    chk("rst_err", sel_err, 1'b0);
    chk("rst6_valid", out_valid6, 1'b0);

    // Out-of-range select on the six-input instance.
    step();
    sel6 = 3'd6; in_valid6 = 1'b1;
    step();
    in_valid6 = 1'b0;
    @(negedge clk);
    chk("r6_valid", out_valid6, 1'b1);
    chk("r6_data", out_data6, 32'h0);
    chk("r6_zero", out_zero6, 1'b1);
    chk("r6_sel", out_sel6, 3'd6);
    chk("r6_err", sel_err6, 1'b1);
    step();
    clr_err6 = 1'b1;
    step();
    clr_err6 = 1'b0;
    @(negedge clk);
    chk("r6_clr", sel_err6, 1'b0);
    // Set and clear together: set wins; accept and pop together from ONE.
    step();
    sel6 = 3'd7; in_valid6 = 1'b1; clr_err6 = 1'b1; out_ready6 = 1'b1;
    step();
    in_valid6 = 1'b0; clr_err6 = 1'b0; out_ready6 = 1'b0;
    @(negedge clk);
    chk("r6_setclr", sel_err6, 1'b1);
    chk("r6_sel7", out_sel6, 3'd7);
    step();
    sel6 = 3'd2; in_valid6 = 1'b1; out_ready6 = 1'b1;
    step();
    in_valid6 = 1'b0; sel6 = 3'd6;
    @(negedge clk);
    chk("r6_in2", out_data6, 32'h2000_0002);
    chk("r6_nz", out_zero6, 1'b0);
    step();
    @(negedge clk);
    chk("r6_drain", out_valid6, 1'b0);
    chk("r6_zero_idle", out_zero6, 1'b0);
    out_ready6 = 1'b0;

    // Single transfer, one-cycle latency, single-cycle visibility.
    step();
    out_ready = 1'b1; sel = 3'd5; in_valid = 1'b1;
    step();
    in_valid = 1'b0; sel = 3'd7;
    @(negedge clk);
    chk("t1_valid", out_valid, 1'b1);
    chk("t1_data", out_data, 32'h1000_0005);
    chk("t1_sel", out_sel, 3'd5);
    step();
    @(negedge clk);
    chk("t1_once", out_valid, 1'b0);

    // Fill to TWO under back-pressure, then drain in order.
    out_ready = 1'b0; sel = 3'd1; in_valid = 1'b1;
    step();
    sel = 3'd2;
    step();
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    chk("t2_full", in_ready, 1'b0);
    chk("t2_head", out_data, 32'h1000_0001);
    step();
    @(negedge clk);
    chk("t2_second", out_data, 32'h1000_0002);
    chk("t2_ready", in_ready, 1'b1);
    step();
    @(negedge clk);
    chk("t2_empty", out_valid, 1'b0);

    // Accept and pop together from ONE.
    out_ready = 1'b0; sel = 3'd3; in_valid = 1'b1;
    step();
    sel = 3'd7; out_ready = 1'b1;
    step();
    in_valid = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    chk("t3_valid", out_valid, 1'b1);
    chk("t3_data", out_data, 32'h1000_0007);
    chk("t3_ready", in_ready, 1'b1);
    out_ready = 1'b1;
    step();

    // Reset while full, overriding a concurrent accept and pop.
    out_ready = 1'b0; sel = 3'd4; in_valid = 1'b1;
    step();
    sel = 3'd6;
    step();
    sel = 3'd0; out_ready = 1'b1; reset = 1'b1;
    step();
    reset = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    chk("t4_valid", out_valid, 1'b0);
    chk("t4_ready", in_ready, 1'b1);
    chk("t4_err", sel_err, 1'b0);
    step();
    sel = 3'd3; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    @(negedge clk);
    chk("t4_first", out_data, 32'h1000_0003);
    out_ready = 1'b1;
    step();
    @(negedge clk);
    chk("t4_no_stale", out_valid, 1'b0);

    // Continuous offers with random back-pressure and data containing zeros.
    for (int c = 0; c < 1000; c++) begin
      for (int k = 0; k < 8; k++)
        in_bus[k*W +: W] = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
      sel       = 3'($urandom_range(0, 7));
      in_valid  = 1'b1;
      out_ready = 1'($urandom_range(0, 1));
      clr_err   = 1'($urandom_range(0, 1));
      step();
    end
    // Idle inputs with changing bus/select must not enqueue anything.
    in_valid = 1'b0; clr_err = 1'b0;
    for (int c = 0; c < 20; c++) begin
      in_bus[0 +: W] = $urandom;
      sel       = 3'($urandom_range(0, 7));
      out_ready = 1'($urandom_range(0, 1));
      step();
    end
    out_ready = 1'b1;
    step(); step(); step();
    @(negedge clk);
    chk("end_empty", out_valid, 1'b0);
    chk("end_ready", in_ready, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
